// File: rtl/vpu_lane_issue_ctrl.sv
// vpu_lane_issue_ctrl: one-in-flight issue/latency-count/capture controller for a VPU lane.
// Define VPU_ISSUE_BACK2BACK_EN to accept the next request in DONE alongside the response handshake.
module vpu_lane_issue_ctrl #(
  parameter int OPERAND_WIDTH = 32,
  parameter int OPERAND_CNT   = 3,
  parameter int MAX_DELAY_LG2 = 4,
  parameter int LAT_UI_ADD    = 1,
  parameter int LAT_UI_MUL    = 2,
  parameter int LAT_UI_DIV    = 8,
  parameter int LAT_FP_ADD    = 3,
  parameter int LAT_FP_MUL    = 3,
  parameter int LAT_FP_DIV    = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [2:0]                           req_op_i,
  input  logic [OPERAND_CNT*OPERAND_WIDTH-1:0] req_operand_i,
  input  logic [OPERAND_CNT-1:0]               req_operand_valid_i,
  output logic                                 start_o,
  output logic [7:0]                           op_func_o,
  output logic [MAX_DELAY_LG2-1:0]             delay_o,
  output logic [OPERAND_CNT*OPERAND_WIDTH-1:0] operand_o,
  output logic [OPERAND_CNT-1:0]               operand_valid_o,
  input  logic [OPERAND_WIDTH-1:0]             lane_dout_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]             rsp_data_o,
  output logic                                 busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [MAX_DELAY_LG2-1:0] L_UA = MAX_DELAY_LG2'(LAT_UI_ADD);
  localparam logic [MAX_DELAY_LG2-1:0] L_UM = MAX_DELAY_LG2'(LAT_UI_MUL);
  localparam logic [MAX_DELAY_LG2-1:0] L_UD = MAX_DELAY_LG2'(LAT_UI_DIV);
  localparam logic [MAX_DELAY_LG2-1:0] L_FA = MAX_DELAY_LG2'(LAT_FP_ADD);
  localparam logic [MAX_DELAY_LG2-1:0] L_FM = MAX_DELAY_LG2'(LAT_FP_MUL);
  localparam logic [MAX_DELAY_LG2-1:0] L_FD = MAX_DELAY_LG2'(LAT_FP_DIV);
  localparam logic [MAX_DELAY_LG2-1:0] ONE  = MAX_DELAY_LG2'(1);
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [MAX_DELAY_LG2-1:0] cnt, lat;
  logic accept, capture;
  // op[2] selects FP, op[1:0]: 0/1 add/sub, 2 mul, 3 div
  assign lat = req_op_i[1] ? (req_op_i[0] ? (req_op_i[2] ? L_FD : L_UD) : (req_op_i[2] ? L_FM : L_UM))
                           : (req_op_i[2] ? L_FA : L_UA);
  always_comb begin
    state_nx    = state;
    req_ready_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nx = ISSUE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = DONE;
      DONE: begin
`ifdef VPU_ISSUE_BACK2BACK_EN
        req_ready_o = rsp_ready_i;
        if (rsp_ready_i) state_nx = req_valid_i ? ISSUE : IDLE;
`else
        if (rsp_ready_i) state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end
  assign accept      = req_valid_i && req_ready_o;
  assign capture     = state == WAIT && cnt == '0;
  assign start_o     = state == ISSUE;
  assign rsp_valid_o = state == DONE;
  assign busy_o      = state != IDLE;
  // lane result mux is combinational on op_func, so it stays up until the capture cycle
  assign op_func_o   = (state == ISSUE || state == WAIT) ? 8'h01 << op_q : 8'h00;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q            <= '0;
      operand_o       <= '0;
      operand_valid_o <= '0;
      delay_o         <= '0;
      cnt             <= '0;
      rsp_data_o      <= '0;
    end else begin
      if (accept) begin
        op_q            <= req_op_i;
        operand_o       <= req_operand_i;
        operand_valid_o <= req_operand_valid_i;
        delay_o         <= lat;
      end
      if (state == ISSUE) cnt <= delay_o - ONE;
      else if (state == WAIT) cnt <= cnt - ONE;
      if (capture) rsp_data_o <= lane_dout_i;
    end
endmodule
